// File: rtl/sv_bus_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin vld/rdy bus arbiter.
package sv_bus_rr_arbiter_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    typedef struct packed {
        logic [BUS_AW-1:0] adr;
        logic [BUS_DW-1:0] dat;
    } bus_t;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/sv_bus_rr_arbiter_if.sv
// Requester-side and arbitrated-side signals of the round-robin bus arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface sv_bus_rr_arbiter_if
    import sv_bus_rr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = BUS_AW,
    parameter int unsigned DW = BUS_DW
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]         req_vld;
    logic [N-1:0][AW-1:0] req_adr;
    logic [N-1:0][DW-1:0] req_dat;
    logic [N-1:0]         req_rdy;
    logic [N-1:0]         req_lck;
    logic                 out_vld;
    logic [AW-1:0]        out_adr;
    logic [DW-1:0]        out_dat;
    logic                 out_rdy;
    logic                 gnt_vld;
    logic [IW-1:0]        gnt_idx;

    modport master (
        input  req_vld, req_adr, req_dat, req_lck, out_rdy,
        output req_rdy, out_vld, out_adr, out_dat, gnt_vld, gnt_idx
    );

    modport slave (
        output req_vld, req_adr, req_dat, req_lck, out_rdy,
        input  req_rdy, out_vld, out_adr, out_dat, gnt_vld, gnt_idx
    );

endinterface

// File: rtl/sv_bus_rr_pick.sv
// Combinational round-robin picker: first set bit of req, searching from start upward
// and wrapping explicitly at N (not at 2^IW).
module sv_bus_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);
    localparam int unsigned SW = IW + 1;

    logic [SW-1:0] sum;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                idx   = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sv_bus_rr_arbiter.sv
// Round-robin arbiter sharing one vld/rdy address+data bus among N requesters.
// Define SV_BUS_ARB_LOCK_EN to let a requester keep the grant across transfers via req_lck.
module sv_bus_rr_arbiter
    import sv_bus_rr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = BUS_AW,
    parameter int unsigned DW = BUS_DW
) (
    input logic                 clk,
    input logic                 rst,
    sv_bus_rr_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_inc;
    logic [IW-1:0] pick_start;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          gnt_vld;
    logic          hold_lck;
    logic [AW-1:0] adr_mux;
    logic [DW-1:0] dat_mux;

    assign gnt_vld = (state_q == BUSY);
    assign idx_inc = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);

    // While busy, the re-pick starts after the current holder so it is considered last.
    assign pick_start = gnt_vld ? idx_inc : ptr_q;

    sv_bus_rr_pick #(
        .N(N)
    ) u_pick (
        .req  (bus.req_vld),
        .start(pick_start),
        .found(pick_found),
        .idx  (pick_idx)
    );

`ifdef SV_BUS_ARB_LOCK_EN
    assign hold_lck = bus.req_lck[gnt_idx_q];
`else
    logic unused_lck;
    assign unused_lck = ^bus.req_lck;
    assign hold_lck   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_idx_d = pick_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req_vld[gnt_idx_q]) begin
                    state_d = IDLE;
                end else if (bus.out_rdy && !hold_lck) begin
                    ptr_d = idx_inc;
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        adr_mux     = '0;
        dat_mux     = '0;
        bus.req_rdy = '0;
        if (gnt_vld) begin
            adr_mux                = bus.req_adr[gnt_idx_q];
            dat_mux                = bus.req_dat[gnt_idx_q];
            bus.req_rdy[gnt_idx_q] = bus.out_rdy;
        end
    end

    assign bus.out_vld = gnt_vld & bus.req_vld[gnt_idx_q];
    assign bus.out_adr = adr_mux;
    assign bus.out_dat = dat_mux;
    assign bus.gnt_vld = gnt_vld;
    assign bus.gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_sv_bus_rr_arbiter.sv
// Scoreboard bench for sv_bus_rr_arbiter: a transfer-level round-robin model predicts
// each cycle's grant and every completed transfer; a negedge monitor compares.
module tb_sv_bus_rr_arbiter;
    import sv_bus_rr_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = BUS_AW;
    localparam int unsigned DW = BUS_DW;
    localparam int unsigned IW = $clog2(N);
`ifdef SV_BUS_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        logic [IW-1:0] idx;
        bus_t          b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sv_bus_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    sv_bus_rr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [AW-1:0] cur_adr[N];
    logic [DW-1:0] cur_dat[N];
    logic          mon_en = 1'b0;

    // What the model says holds during the current cycle.
    logic          cur_g_vld = 1'b0;
    logic [IW-1:0] cur_g_idx = '0;
    logic [N-1:0]  cur_vld = '0;
    logic          cur_rdy = 1'b0;

    // Model state: current holder (if any) and the last requester served.
    logic          m_g_vld;
    logic [IW-1:0] m_g_idx;
    logic [IW-1:0] m_last;

    logic [63:0]   rq[N][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requesting index after `last`, going round the ring once.
    task automatic rr_first(input logic [N-1:0] vld, input logic [IW-1:0] last,
                            output logic found, output logic [IW-1:0] idx);
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(last) + k) % N;
            if (!found && vld[IW'(j)]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    endtask

    task automatic step(input logic [N-1:0] vld, input logic rdy, input logic [N-1:0] lck,
                        output logic srv, output logic [IW-1:0] srv_idx);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            bus.req_adr[i] = cur_adr[i];
            bus.req_dat[i] = cur_dat[i];
        end
        bus.req_vld = vld;
        bus.out_rdy = rdy;
        bus.req_lck = lck;
        cur_g_vld   = m_g_vld;
        cur_g_idx   = m_g_idx;
        cur_vld     = vld;
        cur_rdy     = rdy;
        srv         = 1'b0;
        srv_idx     = '0;
        if (m_g_vld) begin
            if (!vld[m_g_idx]) begin
                m_g_vld = 1'b0;
            end else if (rdy) begin
                e.idx   = m_g_idx;
                e.b.adr = cur_adr[m_g_idx];
                e.b.dat = cur_dat[m_g_idx];
                exp_q.push_back(e);
                srv     = 1'b1;
                srv_idx = m_g_idx;
                if (!LOCK || !lck[m_g_idx]) begin
                    m_last = m_g_idx;
                    rr_first(vld, m_last, m_g_vld, m_g_idx);
                end
            end
        end else begin
            rr_first(vld, m_last, m_g_vld, m_g_idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [N-1:0] vld, input logic rdy, input logic [N-1:0] lck);
        logic          s;
        logic [IW-1:0] si;
        step(vld, rdy, lck, s, si);
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) begin
            cur_adr[i] = AW'($urandom);
            cur_dat[i] = DW'($urandom);
        end
    endtask

    task automatic model_reset();
        m_g_vld   = 1'b0;
        m_g_idx   = '0;
        m_last    = IW'(N - 1);
        cur_g_vld = 1'b0;
        cur_vld   = '0;
        cur_rdy   = 1'b0;
        check("leftover_expected", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // Reset with every requester and out_rdy high, so the zero outputs are meaningful.
    task automatic apply_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        new_data();
        for (int i = 0; i < N; i++) begin
            bus.req_adr[i] = cur_adr[i];
            bus.req_dat[i] = cur_dat[i];
        end
        bus.req_vld = '1;
        bus.req_lck = '0;
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld", 64'(bus.out_vld), 64'(0));
        check("rst_out_bus", {bus.out_adr, bus.out_dat}, 64'(0));
        check("rst_req_rdy", 64'(bus.req_rdy), 64'(0));
        check("rst_gnt_vld", 64'(bus.gnt_vld), 64'(0));
        check("rst_gnt_idx", 64'(bus.gnt_idx), 64'(0));
        bus.req_vld = '0;
        bus.out_rdy = 1'b0;
        rst         = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_vld", 64'(bus.gnt_vld), 64'(cur_g_vld));
            if (cur_g_vld) begin
                check("gnt_idx", 64'(bus.gnt_idx), 64'(cur_g_idx));
                check("out_adr", 64'(bus.out_adr), 64'(cur_adr[cur_g_idx]));
                check("out_dat", 64'(bus.out_dat), 64'(cur_dat[cur_g_idx]));
            end else begin
                check("idle_out_bus", {bus.out_adr, bus.out_dat}, 64'(0));
            end
            check("out_vld", 64'(bus.out_vld), 64'(cur_g_vld & cur_vld[cur_g_idx]));
            check("req_rdy", 64'(bus.req_rdy),
                  64'((cur_g_vld & cur_rdy) ? (N'(1) << cur_g_idx) : N'(0)));
            if (bus.out_vld && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL xfer: got transfer from %0d, expected none (t=%0t)",
                             bus.gnt_idx, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_idx", 64'(bus.gnt_idx), 64'(mon_e.idx));
                    check("xfer_data", {bus.out_adr, bus.out_dat}, mon_e.b);
                end
            end
        end
    end

    initial begin
        logic [N-1:0]  vld;
        logic [N-1:0]  lck;
        logic          rdy;
        logic          srv;
        logic [IW-1:0] sidx;

        m_g_vld = 1'b0;
        m_g_idx = '0;
        m_last  = IW'(N - 1);
        apply_reset();

        // Single requester 2.
        cur_adr[2] = 32'h0000_0010;
        cur_dat[2] = 32'hA5A5_A5A5;
        go(4'b0100, 1'b1, '0);
        go(4'b0100, 1'b1, '0);
        go(4'b0000, 1'b1, '0);
        go(4'b0000, 1'b1, '0);

        // All requesters continuously valid: 0,1,2,3,0,1,2,3 with no bubble.
        apply_reset();
        repeat (9) go(4'b1111, 1'b1, '0);
        go(4'b0000, 1'b0, '0);

        // Backpressure on requester 1 while 3 waits.
        apply_reset();
        go(4'b0010, 1'b0, '0);
        repeat (5) go(4'b1010, 1'b0, '0);
        go(4'b1010, 1'b1, '0);
        go(4'b1000, 1'b1, '0);
        go(4'b0000, 1'b0, '0);

        // Withdrawal leaves the pointer on 0.
        apply_reset();
        go(4'b0001, 1'b0, '0);
        go(4'b0000, 1'b0, '0);
        go(4'b0000, 1'b0, '0);
        go(4'b0011, 1'b1, '0);
        go(4'b0011, 1'b1, '0);
        go(4'b0010, 1'b1, '0);
        go(4'b0000, 1'b0, '0);

        // Asynchronous reset while busy and stalled.
        apply_reset();
        go(4'b0010, 1'b0, '0);
        go(4'b0010, 1'b0, '0);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_rst_out_vld", 64'(bus.out_vld), 64'(0));
        check("async_rst_gnt_vld", 64'(bus.gnt_vld), 64'(0));
        check("async_rst_req_rdy", 64'(bus.req_rdy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        go(4'b0110, 1'b1, '0);
        go(4'b0110, 1'b1, '0);
        go(4'b0100, 1'b1, '0);
        go(4'b0000, 1'b0, '0);

`ifdef SV_BUS_ARB_LOCK_EN
        // Requester 2 locks for two transfers, releases on the third, then 0 is served.
        apply_reset();
        go(4'b0100, 1'b0, 4'b0100);
        go(4'b0101, 1'b1, 4'b0100);
        go(4'b0101, 1'b1, 4'b0100);
        go(4'b0101, 1'b1, 4'b0000);
        go(4'b0001, 1'b1, 4'b0000);
        go(4'b0000, 1'b0, 4'b0000);
`endif

        // Randomised traffic: each requester presents queued words until served.
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() < 3 && $urandom_range(3) == 0) begin
                    rq[i].push_back({$urandom, $urandom});
                end
                vld[i] = (rq[i].size() > 0);
                if (vld[i]) begin
                    cur_adr[i] = rq[i][0][63:32];
                    cur_dat[i] = rq[i][0][31:0];
                end
                lck[i] = ($urandom_range(2) == 0);
            end
            rdy = ($urandom_range(3) != 0);
            step(vld, rdy, lck, srv, sidx);
            if (srv) begin
                void'(rq[sidx].pop_front());
            end
        end
        repeat (3) go(4'b0000, 1'b0, '0);
        check("final_expected_left", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
